// File: rtl/if_id_hazard_ctrl.sv
// ID-stage hazard control for the IF/ID register: load-use, CBZ and flag stall
// detection, branch flush, and saturating stall/flush performance counters.
module if_id_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      decInstruction,
    input  logic             exRegWrite,
    input  logic             exMemRead,
    input  logic             exSetFlags,
    input  logic [4:0]       exRd,
    input  logic             memMemRead,
    input  logic [4:0]       memRd,
    input  logic             brTaken,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexBubble,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] stallEvents,
    output logic [CNT_W-1:0] flushCount
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state_r;
    state_t      state_next_s;

    logic [10:0] op_s;
    logic [4:0]  rn_s;
    logic [4:0]  rm_s;
    logic [4:0]  rt_s;
    logic        use_rn_s;
    logic        use_rm_s;
    logic        use_rt_s;
    logic        is_cbz_s;
    logic        is_bcond_s;
    logic        lu_s;
    logic        cbe_s;
    logic        cbm_s;
    logic        flg_s;
    logic        stall_s;
    logic        unused_imm_s;

    assign op_s         = decInstruction[31:21];
    assign rm_s         = decInstruction[20:16];
    assign rn_s         = decInstruction[9:5];
    assign rt_s         = decInstruction[4:0];
    assign unused_imm_s = ^decInstruction[15:10];

    // XZR (register 31) is hard-wired zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst == src) && (dst != 5'd31);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : (v + CNT_ONE);
    endfunction

    // Decode which source operands the ID-stage instruction actually reads.
    always_comb begin
        use_rn_s   = 1'b0;
        use_rm_s   = 1'b0;
        use_rt_s   = 1'b0;
        is_cbz_s   = 1'b0;
        is_bcond_s = 1'b0;
        casez (op_s)
            11'b10101011000,
            11'b11101011000,
            11'b10001010000,
            11'b11001010000: begin
                use_rn_s = 1'b1;
                use_rm_s = 1'b1;
            end
            11'b11010011010,
            11'b1001000100?,
            11'b11111000010: begin
                use_rn_s = 1'b1;
            end
            11'b11111000000: begin
                use_rn_s = 1'b1;
                use_rt_s = 1'b1;
            end
            11'b10110100???: begin
                is_cbz_s = 1'b1;
                use_rt_s = 1'b1;
            end
            11'b01010100???: begin
                is_bcond_s = 1'b1;
            end
            default: begin
                use_rn_s = 1'b0;
            end
        endcase
    end

    // Hazard terms; CBZ resolves in ID, so it must also wait on ALU and MEM producers.
    always_comb begin
        lu_s    = exMemRead & ((use_rn_s & reg_match(exRd, rn_s)) |
                               (use_rm_s & reg_match(exRd, rm_s)) |
                               (use_rt_s & reg_match(exRd, rt_s)));
        cbe_s   = is_cbz_s & exRegWrite & reg_match(exRd, rt_s);
        cbm_s   = is_cbz_s & memMemRead & reg_match(memRd, rt_s);
        flg_s   = is_bcond_s & exSetFlags;
        stall_s = lu_s | cbe_s | cbm_s | flg_s;
    end

    // Pipeline enables; a branch seen during a stall has stale operands and is ignored.
    always_comb begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        ifidFlush  = 1'b0;
        idexBubble = 1'b1;
        if (!reset) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            ifidFlush  = 1'b0;
            idexBubble = 1'b1;
        end else if (stall_s) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            ifidFlush  = 1'b0;
            idexBubble = 1'b1;
        end else begin
            pcWrite    = 1'b1;
            ifidWrite  = 1'b1;
            ifidFlush  = brTaken;
            idexBubble = 1'b0;
        end
    end

    // Next-state logic: STALL tracks the combinational stall condition.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (stall_s) begin
                    state_next_s = STALL;
                end else begin
                    state_next_s = RUN;
                end
            end
            STALL: begin
                if (stall_s) begin
                    state_next_s = STALL;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCycles <= {CNT_W{1'b0}};
            stallEvents <= {CNT_W{1'b0}};
            flushCount  <= {CNT_W{1'b0}};
        end else begin
            if (stall_s) begin
                stallCycles <= sat_inc(stallCycles);
            end else begin
                stallCycles <= stallCycles;
            end
            if (stall_s && (state_r == RUN)) begin
                stallEvents <= sat_inc(stallEvents);
            end else begin
                stallEvents <= stallEvents;
            end
            if (ifidFlush) begin
                flushCount <= sat_inc(flushCount);
            end else begin
                flushCount <= flushCount;
            end
        end
    end

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Scoreboard bench for if_id_hazard_ctrl: directed stimulus pushes expectations,
// a negedge monitor pops and compares against a 16-bit and a 2-bit counter instance.
module tb_if_id_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] dec;
    logic        ex_rw, ex_mr, ex_sf, mem_mr, br;
    logic [4:0]  ex_rd, mem_rd;

    logic        pc_w, ifid_w, ifid_f, idex_b;
    logic [15:0] sc, se, fc;
    logic        pc_w2, ifid_w2, ifid_f2, idex_b2;
    logic [1:0]  sc2, se2, fc2;

    typedef struct {
        string       name;
        logic [3:0]  ctl;   // {pcWrite, ifidWrite, ifidFlush, idexBubble}
        logic [15:0] sc;
        logic [15:0] se;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference counter model (values after the most recent edge)
    logic [15:0] m_sc, m_se, m_fc;
    logic        m_stall_state;

    if_id_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .decInstruction(dec),
        .exRegWrite(ex_rw), .exMemRead(ex_mr), .exSetFlags(ex_sf), .exRd(ex_rd),
        .memMemRead(mem_mr), .memRd(mem_rd), .brTaken(br),
        .pcWrite(pc_w), .ifidWrite(ifid_w), .ifidFlush(ifid_f), .idexBubble(idex_b),
        .stallCycles(sc), .stallEvents(se), .flushCount(fc)
    );

    if_id_hazard_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .decInstruction(dec),
        .exRegWrite(ex_rw), .exMemRead(ex_mr), .exSetFlags(ex_sf), .exRd(ex_rd),
        .memMemRead(mem_mr), .memRd(mem_rd), .brTaken(br),
        .pcWrite(pc_w2), .ifidWrite(ifid_w2), .ifidFlush(ifid_f2), .idexBubble(idex_b2),
        .stallCycles(sc2), .stallEvents(se2), .flushCount(fc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encodings
    localparam logic [31:0] I_ADDS_5_3_4  = {11'b10101011000, 5'd4, 6'd0, 5'd3, 5'd5};
    localparam logic [31:0] I_ADDS_1_31   = {11'b10101011000, 5'd31, 6'd0, 5'd31, 5'd1};
    localparam logic [31:0] I_CBZ_9       = {8'b10110100, 19'd2, 5'd9};
    localparam logic [31:0] I_CBZ_31      = {8'b10110100, 19'd2, 5'd31};
    localparam logic [31:0] I_BCOND       = {8'b01010100, 19'd4, 5'd0};
    localparam logic [31:0] I_STUR_7_2    = {11'b11111000000, 9'd0, 2'b00, 5'd2, 5'd7};
    localparam logic [31:0] I_ADDI_3_2    = {10'b1001000100, 12'd1, 5'd2, 5'd3};
    localparam logic [31:0] I_B           = {6'b000101, 26'd5};

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [1:0] clip2(input logic [15:0] v);
        return (v > 16'd3) ? 2'd3 : v[1:0];
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".ctl"}, {12'd0, pc_w, ifid_w, ifid_f, idex_b}, {12'd0, e.ctl});
            check({e.name, ".ctl2"}, {12'd0, pc_w2, ifid_w2, ifid_f2, idex_b2}, {12'd0, e.ctl});
            check({e.name, ".stallCycles"}, sc, e.sc);
            check({e.name, ".stallEvents"}, se, e.se);
            check({e.name, ".flushCount"}, fc, e.fc);
            check({e.name, ".stallCycles2"}, {14'd0, sc2}, {14'd0, clip2(e.sc)});
            check({e.name, ".stallEvents2"}, {14'd0, se2}, {14'd0, clip2(e.se)});
            check({e.name, ".flushCount2"}, {14'd0, fc2}, {14'd0, clip2(e.fc)});
        end
    end

    task automatic cyc(input string nm, input logic [31:0] d,
                       input logic rw, input logic mr, input logic sf, input logic [4:0] rd,
                       input logic mmr, input logic [4:0] mrd, input logic b,
                       input logic es, input logic ef);
        exp_t e;
        @(posedge clk);
        #2;
        reset = 1'b1;
        dec = d; ex_rw = rw; ex_mr = mr; ex_sf = sf; ex_rd = rd;
        mem_mr = mmr; mem_rd = mrd; br = b;
        e.name = nm;
        e.ctl  = es ? 4'b0001 : {2'b11, ef, 1'b0};
        e.sc   = m_sc;
        e.se   = m_se;
        e.fc   = m_fc;
        exp_q.push_back(e);
        if (es) m_sc = sat16(m_sc);
        if (es && !m_stall_state) m_se = sat16(m_se);
        if (ef) m_fc = sat16(m_fc);
        m_stall_state = es;
    endtask

    // Assert reset with current inputs left unchanged; effect must be immediate.
    task automatic rst(input string nm);
        exp_t e;
        @(posedge clk);
        #2;
        reset = 1'b0;
        m_sc = 16'd0; m_se = 16'd0; m_fc = 16'd0; m_stall_state = 1'b0;
        e.name = nm;
        e.ctl  = 4'b0001;
        e.sc   = 16'd0;
        e.se   = 16'd0;
        e.fc   = 16'd0;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b0;
        dec = 32'd0; ex_rw = 1'b0; ex_mr = 1'b0; ex_sf = 1'b0; ex_rd = 5'd0;
        mem_mr = 1'b0; mem_rd = 5'd0; br = 1'b1;
        m_sc = 16'd0; m_se = 16'd0; m_fc = 16'd0; m_stall_state = 1'b0;

        rst("reset_init");
        // load-use on Rn
        cyc("lu",        I_ADDS_5_3_4, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("lu_clear",  I_ADDS_5_3_4, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("alu_fwd",   I_ADDS_5_3_4, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        // LDUR -> CBZ: two-cycle stall, then taken branch flushes
        cyc("cbz_ex",    I_CBZ_9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        cyc("cbz_mem",   I_CBZ_9, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
        cyc("cbz_br",    I_CBZ_9, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        cyc("idle",      32'd0,   1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        // XZR never matches
        cyc("xzr_lu",    I_ADDS_1_31, 1'b1, 1'b1, 1'b0, 5'd31, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("xzr_cbm",   I_CBZ_31, 1'b1, 1'b0, 1'b0, 5'd31, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0);
        // flags -> B.cond
        cyc("flg",       I_BCOND, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        cyc("flg_clr",   I_BCOND, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        // ALU -> CBZ one cycle
        cyc("alu_cbz",   I_CBZ_9, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("alu_cbz2",  I_CBZ_9, 1'b0, 1'b0, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        // STUR reads Rt; ADDI reads Rn; B reads nothing
        cyc("stur_rt",   I_STUR_7_2, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("addi_rn",   I_ADDI_3_2, 1'b1, 1'b1, 1'b0, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        cyc("b_nosrc",   I_B,        1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        // brTaken ignored during load-use stall (Rm match)
        cyc("lu_br",     I_ADDS_5_3_4, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        cyc("lu_br2",    I_ADDS_5_3_4, 1'b1, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        // async reset mid-stall with counters nonzero
        rst("reset_mid");
        rst("reset_hold");
        cyc("post_rst",  I_ADDS_5_3_4, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        // long stall: 2-bit counters saturate at 3
        for (int i = 0; i < 6; i++) begin
            cyc("sat", I_ADDS_5_3_4, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        end
        cyc("sat_end",   32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("sat_hold",  32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
